pe_mac_gen2: RTL and testbench

- Second-generation systolic processing element for the 2D multiplier array.
- Runtime-selectable dataflow: output-stationary (local accumulator) or weight-stationary (stored weight, partial sum flows down).
- Adds signed/unsigned arithmetic, a configurable-width saturating accumulator, valid qualification, and a shift-chain result drain so an array column can unload without a wide mux.

---
 rtl/pe_mac_gen2_if.sv | 39 +++
 rtl/pe_mac_gen2.sv | 131 +++++++++++++
 tb/tb_pe_mac_gen2.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_gen2_if.sv
// Bundled operand, pipeline, partial-sum and drain-chain signals of one
// pe_mac_gen2 processing element.
interface pe_mac_gen2_if #(
    parameter int BITWIDTH = 8,
    parameter int ACCWIDTH = 32
);
    logic                mode;
    logic                acc_clear;
    logic                load_weights;
    logic                compute_en;
    logic                in_valid;
    logic [BITWIDTH-1:0] in_data;
    logic [BITWIDTH-1:0] in_weight;
    logic [ACCWIDTH-1:0] in_psum;
    logic [BITWIDTH-1:0] out_data;
    logic [BITWIDTH-1:0] out_weight;
    logic                out_valid;
    logic [ACCWIDTH-1:0] out_psum;
    logic                overflow;
    logic                drain_start;
    logic [ACCWIDTH-1:0] res_in;
    logic                res_in_valid;
    logic [ACCWIDTH-1:0] res_out;
    logic                res_out_valid;

    modport master (
        output mode, acc_clear, load_weights, compute_en, in_valid,
        output in_data, in_weight, in_psum, drain_start, res_in, res_in_valid,
        input  out_data, out_weight, out_valid, out_psum, overflow,
        input  res_out, res_out_valid
    );

    modport slave (
        input  mode, acc_clear, load_weights, compute_en, in_valid,
        input  in_data, in_weight, in_psum, drain_start, res_in, res_in_valid,
        output out_data, out_weight, out_valid, out_psum, overflow,
        output res_out, res_out_valid
    );
endinterface

// File: rtl/pe_mac_gen2.sv
// Systolic PE with runtime output-stationary / weight-stationary dataflow,
// saturating accumulate and a shift-chain result drain.
module pe_mac_gen2 #(
    parameter int BITWIDTH  = 8,
    parameter int ACCWIDTH  = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1,
    parameter int CHAIN_POS = 0
) (
    input  logic          clk,
    input  logic          reset,
    pe_mac_gen2_if.slave  bus
);
    localparam int   PW  = 2 * BITWIDTH;
    localparam int   EW  = ACCWIDTH + 1;
    localparam int   CW  = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;
    localparam logic SGN = (SIGNED != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state_q;
    logic                mode_q;
    logic [BITWIDTH-1:0] w_q;
    logic [ACCWIDTH-1:0] acc_q;
    logic [ACCWIDTH-1:0] psum_q;
    logic [BITWIDTH-1:0] out_data_q;
    logic [BITWIDTH-1:0] out_weight_q;
    logic                out_valid_q;
    logic                ovf_q;
    logic [ACCWIDTH-1:0] res_q;
    logic                res_valid_q;
    logic [CW-1:0]       cnt_q;

    // One shared multiply-add: WS uses the stored weight and the incoming
    // partial sum, OS uses the streaming weight and the local accumulator.
    logic [BITWIDTH-1:0] w_op;
    logic [ACCWIDTH-1:0] addend;
    logic [PW-1:0]       d_ext, w_ext, prod;
    logic [EW-1:0]       a_ext, p_ext, sum_raw;
    logic [ACCWIDTH-1:0] sum_val;
    logic                sum_ovf;

    // NOTE: every always_comb output gets a full default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_op    = mode_q ? w_q : bus.in_weight;
        addend  = mode_q ? bus.in_psum : acc_q;
        d_ext   = {{BITWIDTH{SGN & bus.in_data[BITWIDTH-1]}}, bus.in_data};
        w_ext   = {{BITWIDTH{SGN & w_op[BITWIDTH-1]}}, w_op};
        prod    = d_ext * w_ext;
        a_ext   = {SGN & addend[ACCWIDTH-1], addend};
        p_ext   = {{(EW-PW){SGN & prod[PW-1]}}, prod};
        sum_raw = a_ext + p_ext;
        sum_ovf = SGN ? (sum_raw[EW-1] != sum_raw[EW-2]) : sum_raw[EW-1];
        sum_val = sum_raw[ACCWIDTH-1:0];
        if (sum_ovf && (SATURATE != 0)) begin
            if (!SGN)              sum_val = '1;
            else if (sum_raw[EW-1]) sum_val = {1'b1, {(ACCWIDTH-1){1'b0}}};
            else                    sum_val = {1'b0, {(ACCWIDTH-1){1'b1}}};
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch
    // reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            w_q          <= '0;
            acc_q        <= '0;
            psum_q       <= '0;
            out_data_q   <= '0;
            out_weight_q <= '0;
            out_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (state_q == ST_IDLE && !bus.compute_en)
                mode_q <= bus.mode;

            if (bus.acc_clear) begin
                acc_q       <= '0;
                ovf_q       <= 1'b0;
                res_valid_q <= 1'b0;
                cnt_q       <= '0;
                state_q     <= ST_IDLE;
            end else if (mode_q && bus.load_weights) begin
                w_q          <= bus.in_weight;
                out_weight_q <= bus.in_weight;
            end else if (!mode_q && bus.drain_start && state_q != ST_DRAIN) begin
                res_q       <= acc_q;
                res_valid_q <= 1'b1;
                cnt_q       <= CW'(CHAIN_POS);
                state_q     <= ST_DRAIN;
            end else if (state_q == ST_DRAIN) begin
                // Pass upstream results through, then retire our own accumulator.
                if (cnt_q != '0) begin
                    res_q       <= bus.res_in;
                    res_valid_q <= bus.res_in_valid;
                    cnt_q       <= cnt_q - CW'(1);
                end else begin
                    res_valid_q <= 1'b0;
                    acc_q       <= '0;
                    state_q     <= ST_IDLE;
                end
            end else if (bus.compute_en) begin
                out_data_q   <= bus.in_data;
                out_weight_q <= bus.in_weight;
                out_valid_q  <= bus.in_valid;
                if (bus.in_valid) begin
                    if (mode_q) psum_q <= sum_val;
                    else        acc_q  <= sum_val;
                    if (sum_ovf) ovf_q <= 1'b1;
                    state_q <= ST_ACCUM;
                end
            end
        end
    end

    assign bus.out_data      = out_data_q;
    assign bus.out_weight    = out_weight_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_psum      = mode_q ? psum_q : acc_q;
    assign bus.overflow      = ovf_q;
    assign bus.res_out       = res_q;
    assign bus.res_out_valid = res_valid_q;
endmodule

// File: tb/tb_pe_mac_gen2.sv
// Directed bench for pe_mac_gen2: four instances (signed/32 with a 3-deep drain,
// unsigned/32, signed/16 saturating, signed/16 wrapping) share one stimulus.
module tb_pe_mac_gen2;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode, acc_clear, load_weights, compute_en, in_valid;
    logic [7:0]  in_data, in_weight;
    logic [31:0] in_psum, res_in;
    logic        drain_start, res_in_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_mac_gen2_if #(.BITWIDTH(8), .ACCWIDTH(32)) if_a ();
    pe_mac_gen2_if #(.BITWIDTH(8), .ACCWIDTH(32)) if_u ();
    pe_mac_gen2_if #(.BITWIDTH(8), .ACCWIDTH(16)) if_s ();
    pe_mac_gen2_if #(.BITWIDTH(8), .ACCWIDTH(16)) if_w ();

    assign if_a.mode = mode;           assign if_a.acc_clear = acc_clear;
    assign if_a.load_weights = load_weights; assign if_a.compute_en = compute_en;
    assign if_a.in_valid = in_valid;   assign if_a.in_data = in_data;
    assign if_a.in_weight = in_weight; assign if_a.in_psum = in_psum;
    assign if_a.drain_start = drain_start; assign if_a.res_in = res_in;
    assign if_a.res_in_valid = res_in_valid;

    assign if_u.mode = mode;           assign if_u.acc_clear = acc_clear;
    assign if_u.load_weights = load_weights; assign if_u.compute_en = compute_en;
    assign if_u.in_valid = in_valid;   assign if_u.in_data = in_data;
    assign if_u.in_weight = in_weight; assign if_u.in_psum = in_psum;
    assign if_u.drain_start = drain_start; assign if_u.res_in = res_in;
    assign if_u.res_in_valid = res_in_valid;

    assign if_s.mode = mode;           assign if_s.acc_clear = acc_clear;
    assign if_s.load_weights = load_weights; assign if_s.compute_en = compute_en;
    assign if_s.in_valid = in_valid;   assign if_s.in_data = in_data;
    assign if_s.in_weight = in_weight; assign if_s.in_psum = in_psum[15:0];
    assign if_s.drain_start = drain_start; assign if_s.res_in = res_in[15:0];
    assign if_s.res_in_valid = res_in_valid;

    assign if_w.mode = mode;           assign if_w.acc_clear = acc_clear;
    assign if_w.load_weights = load_weights; assign if_w.compute_en = compute_en;
    assign if_w.in_valid = in_valid;   assign if_w.in_data = in_data;
    assign if_w.in_weight = in_weight; assign if_w.in_psum = in_psum[15:0];
    assign if_w.drain_start = drain_start; assign if_w.res_in = res_in[15:0];
    assign if_w.res_in_valid = res_in_valid;

    pe_mac_gen2 #(.BITWIDTH(8), .ACCWIDTH(32), .SIGNED(1), .SATURATE(1), .CHAIN_POS(2))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    pe_mac_gen2 #(.BITWIDTH(8), .ACCWIDTH(32), .SIGNED(0), .SATURATE(1), .CHAIN_POS(0))
        u_u (.clk(clk), .reset(reset), .bus(if_u));
    pe_mac_gen2 #(.BITWIDTH(8), .ACCWIDTH(16), .SIGNED(1), .SATURATE(1), .CHAIN_POS(0))
        u_s (.clk(clk), .reset(reset), .bus(if_s));
    pe_mac_gen2 #(.BITWIDTH(8), .ACCWIDTH(16), .SIGNED(1), .SATURATE(0), .CHAIN_POS(0))
        u_w (.clk(clk), .reset(reset), .bus(if_w));

    typedef struct {
        logic        clr, ce, vld;
        logic [7:0]  d, w;
        logic [31:0] ea, eu;
        logic [15:0] es, ew;
        logic [7:0]  edata, eweight;
        logic        evld, eso, ewo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 1'b0; acc_clear = 1'b0; load_weights = 1'b0; compute_en = 1'b0;
        in_valid = 1'b0; in_data = '0; in_weight = '0; in_psum = '0;
        drain_start = 1'b0; res_in = '0; res_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // clr ce vld  d  w  | a  u  s  w(16) | out_data out_weight out_valid s_ovf w_ovf
        vecs[0]  = '{1'b0,1'b1,1'b1,8'h03,8'h04,32'd12,32'd12,16'd12,16'd12,8'h03,8'h04,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,8'hFE,8'h05,32'd2,32'd1282,16'd2,16'd2,8'hFE,8'h05,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,8'h7F,8'h7F,32'd16131,32'd17411,16'd16131,16'd16131,8'h7F,8'h7F,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,8'h09,8'h09,32'd16131,32'd17411,16'd16131,16'd16131,8'h09,8'h09,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,8'h01,8'h01,32'd16131,32'd17411,16'd16131,16'd16131,8'h09,8'h09,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b1,8'hFF,8'hFF,32'd16132,32'd82436,16'd16132,16'd16132,8'hFF,8'hFF,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,32'd0,32'd0,16'd0,16'd0,8'hFF,8'hFF,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b1,8'h7F,8'h7F,32'd16129,32'd16129,16'd16129,16'd16129,8'h7F,8'h7F,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b1,8'h7F,8'h7F,32'd32258,32'd32258,16'd32258,16'd32258,8'h7F,8'h7F,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b1,8'h7F,8'h7F,32'd48387,32'd48387,16'h7FFF,16'hBD03,8'h7F,8'h7F,1'b1,1'b1,1'b1};
        vecs[10] = '{1'b0,1'b1,1'b0,8'h00,8'h00,32'd48387,32'd48387,16'h7FFF,16'hBD03,8'h00,8'h00,1'b0,1'b1,1'b1};
        vecs[11] = '{1'b1,1'b0,1'b0,8'h00,8'h00,32'd0,32'd0,16'd0,16'd0,8'h00,8'h00,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,8'hFF,8'hFF,32'd1,32'd65025,16'd1,16'd1,8'hFF,8'hFF,1'b1,1'b0,1'b0};

        // Reset state
        do_reset();
        check("reset psum", if_a.out_psum, 32'd0);
        check("reset out_valid", if_a.out_valid, 1'b0);
        check("reset overflow", if_a.overflow, 1'b0);
        check("reset res_out_valid", if_a.res_out_valid, 1'b0);

        // OS accumulate, hold, saturate/wrap, unsigned
        for (int i = 0; i < 13; i++) begin
            acc_clear = vecs[i].clr; compute_en = vecs[i].ce; in_valid = vecs[i].vld;
            in_data = vecs[i].d; in_weight = vecs[i].w;
            step();
            check($sformatf("row%0d psum_a", i), if_a.out_psum, vecs[i].ea);
            check($sformatf("row%0d psum_u", i), if_u.out_psum, vecs[i].eu);
            check($sformatf("row%0d psum_s", i), if_s.out_psum, vecs[i].es);
            check($sformatf("row%0d psum_w", i), if_w.out_psum, vecs[i].ew);
            check($sformatf("row%0d out_data", i), if_a.out_data, vecs[i].edata);
            check($sformatf("row%0d out_weight", i), if_a.out_weight, vecs[i].eweight);
            check($sformatf("row%0d out_valid", i), if_a.out_valid, vecs[i].evld);
            check($sformatf("row%0d ovf_a", i), if_a.overflow, 1'b0);
            check($sformatf("row%0d ovf_s", i), if_s.overflow, vecs[i].eso);
            check($sformatf("row%0d ovf_w", i), if_w.overflow, vecs[i].ewo);
        end

        // WS: latch mode in IDLE, load weight, compute, load beats compute
        do_reset();
        mode = 1'b1;
        step();
        load_weights = 1'b1; compute_en = 1'b1; in_weight = 8'hFD;
        step();
        check("ws load out_weight", if_a.out_weight, 8'hFD);
        load_weights = 1'b0; in_weight = 8'h11; in_data = 8'd7; in_psum = 32'd100; in_valid = 1'b1;
        step();
        check("ws psum", if_a.out_psum, 32'd79);
        check("ws out_weight", if_a.out_weight, 8'h11);
        check("ws out_data", if_a.out_data, 8'd7);
        load_weights = 1'b1; in_weight = 8'h02; in_data = 8'd9; in_psum = 32'd500;
        step();
        check("ws load-wins psum", if_a.out_psum, 32'd79);
        check("ws load-wins out_weight", if_a.out_weight, 8'h02);
        check("ws load-wins out_data", if_a.out_data, 8'd7);
        load_weights = 1'b0; in_weight = 8'h00; in_data = 8'd7; in_psum = 32'd0;
        step();
        check("ws new weight psum", if_a.out_psum, 32'd14);
        in_valid = 1'b0; in_psum = 32'd999;
        step();
        check("ws invalid hold", if_a.out_psum, 32'd14);

        // OS drain through a 3-deep chain
        do_reset();
        compute_en = 1'b1; in_valid = 1'b1; in_data = 8'd6; in_weight = 8'd7;
        step();
        check("drain pre acc", if_a.out_psum, 32'd42);
        in_valid = 1'b0; drain_start = 1'b1;
        step();
        check("drain T+1 res_out", if_a.res_out, 32'd42);
        check("drain T+1 valid", if_a.res_out_valid, 1'b1);
        drain_start = 1'b0; res_in = 32'd10; res_in_valid = 1'b1;
        in_valid = 1'b1; in_data = 8'd1; in_weight = 8'd1;
        step();
        check("drain T+2 res_out", if_a.res_out, 32'd10);
        check("drain T+2 valid", if_a.res_out_valid, 1'b1);
        check("drain T+2 acc frozen", if_a.out_psum, 32'd42);
        res_in = 32'd20;
        step();
        check("drain T+3 res_out", if_a.res_out, 32'd20);
        check("drain T+3 valid", if_a.res_out_valid, 1'b1);
        res_in = 32'd0; res_in_valid = 1'b0; in_valid = 1'b0;
        step();
        check("drain T+4 valid", if_a.res_out_valid, 1'b0);
        check("drain T+4 acc", if_a.out_psum, 32'd0);
        check("drain out_data held", if_a.out_data, 8'd6);
        in_valid = 1'b1; in_data = 8'd2; in_weight = 8'd3;
        step();
        check("post-drain compute", if_a.out_psum, 32'd6);

        // Abort a drain with acc_clear at T+2
        in_valid = 1'b0; drain_start = 1'b1;
        step();
        check("abort T+1 res_out", if_a.res_out, 32'd6);
        drain_start = 1'b0; res_in = 32'd10; res_in_valid = 1'b1;
        step();
        acc_clear = 1'b1;
        step();
        check("abort valid", if_a.res_out_valid, 1'b0);
        check("abort acc", if_a.out_psum, 32'd0);
        acc_clear = 1'b0; res_in_valid = 1'b0; in_valid = 1'b1; in_data = 8'd1; in_weight = 8'd5;
        step();
        check("post-abort compute", if_a.out_psum, 32'd5);
        in_valid = 1'b0;
        step();
        check("post-abort res valid", if_a.res_out_valid, 1'b0);

        // Reset mid-accumulate
        in_valid = 1'b1; in_data = 8'd3; in_weight = 8'd4;
        step();
        check("pre-reset acc", if_a.out_psum, 32'd17);
        reset = 1'b1;
        step();
        check("mid reset psum", if_a.out_psum, 32'd0);
        check("mid reset out_data", if_a.out_data, 8'd0);
        check("mid reset out_weight", if_a.out_weight, 8'd0);
        check("mid reset out_valid", if_a.out_valid, 1'b0);
        check("mid reset res_out", if_a.res_out, 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
